// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard controller: forwarding
// select codes, stall FSM state type and flush-vector bit positions.
package mips_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam int FL_IFID  = 0;
  localparam int FL_IDEX  = 1;
  localparam int FL_EXMEM = 2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_LWAIT = 1'b1
  } hz_state_e;

  // Stages younger than the resolving stage are cleared on a redirect.
  function automatic logic [2:0] flush_vec(input int br_stage);
    logic [2:0] v;
    v = '0;
    if (br_stage == 2) begin
      v[FL_IFID] = 1'b1;
      v[FL_IDEX] = 1'b1;
    end else if (br_stage == 3) begin
      v[FL_IFID]  = 1'b1;
      v[FL_IDEX]  = 1'b1;
      v[FL_EXMEM] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle. The slave modport is the controller,
// the master modport is the core. Perf counters exist only with HAZ_PERF_EN.
interface hazard_ctrl_if
  import mips_pkg::*;
#(
  parameter int REG_AW = 5
) ();

  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regw;
  logic              ex_memr;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regw;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regw;
  logic              redirect;

  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              pc_hold;
  logic              if_id_hold;
  logic              id_ex_bubble;
  logic [2:0]        flush;
  logic              busy;
  hz_state_e         dbg_state;
`ifdef HAZ_PERF_EN
  logic [31:0]       perf_stall;
  logic [31:0]       perf_flush;
`endif

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_rs, ex_rt, ex_rd, ex_regw,
           ex_memr, mem_rd, mem_regw, wb_rd, wb_regw, redirect,
    input  fwd_a, fwd_b, pc_hold, if_id_hold, id_ex_bubble, flush, busy,
           dbg_state
`ifdef HAZ_PERF_EN
    , input perf_stall, perf_flush
`endif
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rs, ex_rt, ex_rd, ex_regw,
           ex_memr, mem_rd, mem_regw, wb_rd, wb_regw, redirect,
    output fwd_a, fwd_b, pc_hold, if_id_hold, id_ex_bubble, flush, busy,
           dbg_state
`ifdef HAZ_PERF_EN
    , output perf_stall, perf_flush
`endif
  );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one EX operand; the younger producer in MEM has
// priority over WB, and register 0 is never forwarded.
module fwd_sel
  import mips_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_regw_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_regw_i,
  output logic [1:0]        sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (mem_regw_i && (mem_rd_i != '0) && (mem_rd_i == src_i)) begin
      sel_o = FWD_MEM;
    end else if (wb_regw_i && (wb_rd_i != '0) && (wb_rd_i == src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding selects, load-use bubble FSM and
// redirect flush sequencing. Define HAZ_PERF_EN for stall/flush perf counters.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int LOAD_BUBBLES = 1,
  parameter int BR_STAGE     = 2
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hif
);

  localparam logic [2:0] FLUSH_VEC = flush_vec(BR_STAGE);
  localparam logic [2:0] CNT_LOAD  = 3'(LOAD_BUBBLES - 1);

  hz_state_e  state_q;
  logic [2:0] cnt_q;
  logic       hz;
  logic       stall;
  logic [2:0] flush_d;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .src_i      (hif.ex_rs),
    .mem_rd_i   (hif.mem_rd),
    .mem_regw_i (hif.mem_regw),
    .wb_rd_i    (hif.wb_rd),
    .wb_regw_i  (hif.wb_regw),
    .sel_o      (fwd_a_raw)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .src_i      (hif.ex_rt),
    .mem_rd_i   (hif.mem_rd),
    .mem_regw_i (hif.mem_regw),
    .wb_rd_i    (hif.wb_rd),
    .wb_regw_i  (hif.wb_regw),
    .sel_o      (fwd_b_raw)
  );

  assign hz = hif.ex_memr && hif.ex_regw && (hif.ex_rd != '0) &&
              ((hif.id_use_rs && (hif.id_rs == hif.ex_rd)) ||
               (hif.id_use_rt && (hif.id_rt == hif.ex_rd)));

  // Redirect squashes the stalled consumer, so it always wins over a stall.
  always_comb begin
    stall   = 1'b0;
    flush_d = '0;
    if (!rst) begin
      if (hif.redirect) begin
        flush_d = FLUSH_VEC;
      end else if (state_q == ST_LWAIT) begin
        stall = 1'b1;
      end else if (hz) begin
        stall = 1'b1;
      end
    end
  end

  // The first bubble is issued from RUN; LWAIT supplies the remaining ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!hif.redirect && hz && (LOAD_BUBBLES > 1)) begin
            state_q <= ST_LWAIT;
            cnt_q   <= CNT_LOAD;
          end
        end
        ST_LWAIT: begin
          if (hif.redirect || (cnt_q == 3'd1)) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign hif.fwd_a        = rst ? FWD_RF : fwd_a_raw;
  assign hif.fwd_b        = rst ? FWD_RF : fwd_b_raw;
  assign hif.pc_hold      = stall;
  assign hif.if_id_hold   = stall;
  assign hif.id_ex_bubble = stall;
  assign hif.flush        = flush_d;
  assign hif.busy         = !rst && (state_q == ST_LWAIT);
  assign hif.dbg_state    = state_q;

`ifdef HAZ_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall)        perf_stall_q <= perf_stall_q + 32'd1;
      if (hif.redirect) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign hif.perf_stall = perf_stall_q;
  assign hif.perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: three instances (LOAD_BUBBLES/BR_STAGE
// = 1/2, 3/3, 4/2) share stimulus and are checked against a bubble-count model.
module tb_hazard_ctrl;
  import mips_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs, id_use_rt, ex_regw, ex_memr, mem_regw, wb_regw, redirect;

  int         n_cmp  = 0;
  int         n_fail = 0;

  // Model parameters per instance, taken straight from the instantiations below.
  int         lb_p [N] = '{1, 3, 4};
  logic [2:0] fv_p [N] = '{3'b011, 3'b111, 3'b011};
  int         left_m [N];
  int         pst_m [N];
  int         pfl_m [N];
  logic [10:0] exp_v [N];
  logic [10:0] obs [N];

  hazard_ctrl_if #(.REG_AW(5)) hif [N] ();

  hazard_ctrl #(.REG_AW(5), .LOAD_BUBBLES(1), .BR_STAGE(2)) dut0 (.clk(clk), .rst(rst), .hif(hif[0]));
  hazard_ctrl #(.REG_AW(5), .LOAD_BUBBLES(3), .BR_STAGE(3)) dut1 (.clk(clk), .rst(rst), .hif(hif[1]));
  hazard_ctrl #(.REG_AW(5), .LOAD_BUBBLES(4), .BR_STAGE(2)) dut2 (.clk(clk), .rst(rst), .hif(hif[2]));

  for (genvar g = 0; g < N; g++) begin : g_conn
    assign hif[g].id_rs     = id_rs;
    assign hif[g].id_rt     = id_rt;
    assign hif[g].id_use_rs = id_use_rs;
    assign hif[g].id_use_rt = id_use_rt;
    assign hif[g].ex_rs     = ex_rs;
    assign hif[g].ex_rt     = ex_rt;
    assign hif[g].ex_rd     = ex_rd;
    assign hif[g].ex_regw   = ex_regw;
    assign hif[g].ex_memr   = ex_memr;
    assign hif[g].mem_rd    = mem_rd;
    assign hif[g].mem_regw  = mem_regw;
    assign hif[g].wb_rd     = wb_rd;
    assign hif[g].wb_regw   = wb_regw;
    assign hif[g].redirect  = redirect;
    assign obs[g] = {hif[g].fwd_a, hif[g].fwd_b, hif[g].pc_hold, hif[g].if_id_hold,
                     hif[g].id_ex_bubble, hif[g].flush, hif[g].busy};
  end

  // ---------------- reference model ----------------
  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (mem_regw && mem_rd != 0 && mem_rd == src) return 2'b10;
    if (wb_regw && wb_rd != 0 && wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_hz();
    return ex_memr && ex_regw && ex_rd != 0 &&
           ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
  endfunction

  // Waits for the sampling edge and fills exp_v from current inputs and model state.
  task automatic settle();
    logic       hold;
    logic [2:0] fl;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      hold = 1'b0;
      fl   = 3'b000;
      if (rst) begin
        exp_v[k] = '0;
      end else begin
        if (redirect) fl = fv_p[k];
        else if (left_m[k] > 0) hold = 1'b1;
        else if (m_hz()) hold = 1'b1;
        exp_v[k] = {m_fwd(ex_rs), m_fwd(ex_rt), hold, hold, hold, fl, left_m[k] > 0};
      end
    end
  endtask

  // Commits the model for this cycle and moves past the next rising edge.
  task automatic advance();
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        left_m[k] = 0; pst_m[k] = 0; pfl_m[k] = 0;
      end else begin
        if (exp_v[k][4]) pst_m[k]++;
        if (redirect) pfl_m[k]++;
        if (redirect) left_m[k] = 0;
        else if (left_m[k] > 0) left_m[k]--;
        else if (m_hz()) left_m[k] = lb_p[k] - 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regw = 0; ex_memr = 0;
    mem_rd = 0; mem_regw = 0; wb_rd = 0; wb_regw = 0; redirect = 0;
  endtask

  // lw r5 in EX with the ID instruction reading rt = r5.
  task automatic set_load_use();
    ex_memr = 1; ex_regw = 1; ex_rd = 5; id_use_rt = 1; id_rt = 5;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    id_rs = 5; id_rt = 5; id_use_rt = 1; ex_memr = 1; ex_regw = 1; ex_rd = 5;
    mem_regw = 1; mem_rd = 7; ex_rs = 7; redirect = 1;
    settle();
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (obs[k] !== exp_v[k]) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %b want %b", k, obs[k], exp_v[k]);
      end
    end
    advance();
    clear_inputs();
    settle();
    advance();
    rst = 0;
  endtask

  task automatic test_forwarding();
    logic [4:0] cases [3][5];
    // {ex_rs, ex_rt, mem_rd, wb_rd, regw}: MEM beats WB, rd=0 never forwards, WB-only.
    cases = '{'{5'd3, 5'd4, 5'd3, 5'd3, 5'd1}, '{5'd0, 5'd0, 5'd0, 5'd0, 5'd1},
              '{5'd9, 5'd6, 5'd2, 5'd6, 5'd1}};
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      ex_rs = cases[c][0]; ex_rt = cases[c][1]; mem_rd = cases[c][2]; wb_rd = cases[c][3];
      mem_regw = cases[c][4][0]; wb_regw = cases[c][4][0];
      settle();
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if (obs[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL fwd case%0d dut%0d: got %b want %b", c, k, obs[k], exp_v[k]);
        end
      end
      n_cmp++;
      if (obs[0][10:7] !== (c == 0 ? 4'b1000 : c == 1 ? 4'b0000 : 4'b0001)) begin
        n_fail++;
        $display("FAIL fwd_ab case%0d: got %b", c, obs[0][10:7]);
      end
      advance();
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    int bub [N];
    for (int k = 0; k < N; k++) bub[k] = 0;
    set_load_use();
    for (int cyc = 0; cyc < 7; cyc++) begin
      settle();
      for (int k = 0; k < N; k++) begin
        bub[k] += obs[k][4];
        n_cmp++;
        if (obs[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL load_use cyc%0d dut%0d: got %b want %b", cyc, k, obs[k], exp_v[k]);
        end
      end
      advance();
      clear_inputs();
    end
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (bub[k] != lb_p[k]) begin
        n_fail++;
        $display("FAIL bubble_count dut%0d: got %0d want %0d", k, bub[k], lb_p[k]);
      end
    end
  endtask

  task automatic test_redirect_hz();
    set_load_use();
    redirect = 1;
    settle();
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (obs[k] !== exp_v[k]) begin
        n_fail++;
        $display("FAIL redirect_hz dut%0d: got %b want %b", k, obs[k], exp_v[k]);
      end
    end
    advance();
    clear_inputs();
    settle();
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (obs[k] !== exp_v[k] || hif_state(k) !== ST_RUN) begin
        n_fail++;
        $display("FAIL redirect_hz_after dut%0d: got %b want %b", k, obs[k], exp_v[k]);
      end
    end
    advance();
  endtask

  function automatic hz_state_e hif_state(input int k);
    case (k)
      0:       return hif[0].dbg_state;
      1:       return hif[1].dbg_state;
      default: return hif[2].dbg_state;
    endcase
  endfunction

  // Redirect on overall cycle 3, the second LWAIT cycle of the 4-bubble instance.
  task automatic test_redirect_lwait();
    set_load_use();
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (cyc == 2) redirect = 1;
      settle();
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if (obs[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL redirect_lwait cyc%0d dut%0d: got %b want %b", cyc, k, obs[k], exp_v[k]);
        end
      end
      advance();
      clear_inputs();
    end
  endtask

  task automatic test_back_to_back();
    for (int cyc = 0; cyc < 3; cyc++) begin
      redirect = 1;
      settle();
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if (obs[k][3:1] !== fv_p[k] || obs[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL b2b_redirect cyc%0d dut%0d: got %b want %b", cyc, k, obs[k], exp_v[k]);
        end
      end
      advance();
    end
    clear_inputs();
  endtask

  task automatic test_rst_mid_lwait();
    set_load_use();
    for (int cyc = 0; cyc < 5; cyc++) begin
      rst = (cyc == 1);
      settle();
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if (obs[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL rst_mid_lwait cyc%0d dut%0d: got %b want %b", cyc, k, obs[k], exp_v[k]);
        end
      end
      advance();
      clear_inputs();
    end
    rst = 0;
  endtask

`ifdef HAZ_PERF_EN
  task automatic test_perf();
    rst = 1; settle(); advance(); rst = 0;
    for (int h = 0; h < 2; h++) begin
      set_load_use(); settle(); advance(); clear_inputs();
      for (int i = 0; i < 4; i++) begin settle(); advance(); end
    end
    redirect = 1; settle(); advance(); clear_inputs();
    settle();
    n_cmp++;
    if (hif[1].perf_stall !== 32'd6 || hif[1].perf_flush !== 32'd1) begin
      n_fail++;
      $display("FAIL perf_counts: got %0d/%0d want 6/1", hif[1].perf_stall, hif[1].perf_flush);
    end
    n_cmp++;
    if (hif[2].perf_stall !== 32'(pst_m[2]) || hif[0].perf_flush !== 32'(pfl_m[0])) begin
      n_fail++;
      $display("FAIL perf_model: got %0d/%0d want %0d/%0d", hif[2].perf_stall,
               hif[0].perf_flush, pst_m[2], pfl_m[0]);
    end
    advance();
    rst = 1; settle(); advance(); rst = 0;
    settle();
    n_cmp++;
    if (hif[1].perf_stall !== 32'd0 || hif[1].perf_flush !== 32'd0 || obs[1] !== exp_v[1]) begin
      n_fail++;
      $display("FAIL perf_reset: got %0d/%0d outs %b", hif[1].perf_stall, hif[1].perf_flush, obs[1]);
    end
    advance();
  endtask
`endif

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst       = ($urandom_range(0, 39) == 0);
      id_rs     = 5'($urandom_range(0, 3));
      id_rt     = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom_range(0, 1));
      id_use_rt = 1'($urandom_range(0, 1));
      ex_rs     = 5'($urandom_range(0, 3));
      ex_rt     = 5'($urandom_range(0, 3));
      ex_rd     = 5'($urandom_range(0, 3));
      ex_regw   = 1'($urandom_range(0, 1));
      ex_memr   = ($urandom_range(0, 2) == 0);
      mem_rd    = 5'($urandom_range(0, 3));
      mem_regw  = 1'($urandom_range(0, 1));
      wb_rd     = 5'($urandom_range(0, 3));
      wb_regw   = 1'($urandom_range(0, 1));
      redirect  = ($urandom_range(0, 7) == 0);
      settle();
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if (obs[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL random cyc%0d dut%0d: got %b want %b", cyc, k, obs[k], exp_v[k]);
        end
      end
      advance();
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      left_m[k] = 0; pst_m[k] = 0; pfl_m[k] = 0; exp_v[k] = '0;
    end
    clear_inputs();
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_redirect_hz();
    test_redirect_lwait();
    test_back_to_back();
    test_rst_mid_lwait();
`ifdef HAZ_PERF_EN
    test_perf();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the 5-stage MIPS core.
- Generates EX-stage operand forwarding selects.
- Inserts a programmable number of load-use bubbles using a small stall FSM.
- Sequences branch/jump redirect flushes for a configurable resolve stage.
- Replaces the ad-hoc forwarding and bubble logic in the core top; sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
REG_AW, 5, register-index width; index 0 is hard-zero and never forwarded or stalled on.
LOAD_BUBBLES, 1, bubble cycles inserted per load-use hazard; legal 1..7.
BR_STAGE, 2, stage where a redirect resolves: 2 = EX, 3 = MEM.

Ports:
clk  in  1  core clock
rst  in  1  reset
id_rs  in  REG_AW  rs of instruction in ID
id_rt  in  REG_AW  rt of instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
ex_rs  in  REG_AW  rs of instruction in EX
ex_rt  in  REG_AW  rt of instruction in EX
ex_rd  in  REG_AW  destination of instruction in EX
ex_regw  in  1  EX instruction writes RF
ex_memr  in  1  EX instruction is a load
mem_rd  in  REG_AW  destination in MEM
mem_regw  in  1  MEM instruction writes RF
wb_rd  in  REG_AW  destination in WB
wb_regw  in  1  WB instruction writes RF
redirect  in  1  taken branch/jump resolved in BR_STAGE this cycle
fwd_a  out  2  EX operand A select: 00 RF, 10 EX/MEM ALU result, 01 WB data
fwd_b  out  2  EX operand B select, same encoding
pc_hold  out  1  freeze PC
if_id_hold  out  1  freeze IF/ID
id_ex_bubble  out  1  load NOP into ID/EX
flush  out  3  bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM clear-to-NOP
busy  out  1  FSM not in RUN

Behaviour:
Reset is synchronous and active-high on rst, sampled at the rising edge of clk. It forces state RUN and counter 0. While rst is high, all outputs read 0.

Forwarding (combinational, from pipeline registers):
- fwd_a = 10 if mem_regw && mem_rd != 0 && mem_rd == ex_rs.
- Else fwd_a = 01 if wb_regw && wb_rd != 0 && wb_rd == ex_rs.
- Else fwd_a = 00.
- fwd_b is identical using ex_rt.
- MEM beats WB when both match.

Load-use detect: hz = ex_memr && ex_regw && ex_rd != 0 && ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd)).

FSM states: RUN, LWAIT.
- RUN:
  - If redirect: assert flush for one cycle; stay in RUN.
  - Else if hz: assert pc_hold, if_id_hold, id_ex_bubble this cycle.
    - If LOAD_BUBBLES > 1: load cnt = LOAD_BUBBLES-1 and go to LWAIT.
    - Otherwise stay in RUN.
- LWAIT: assert pc_hold, if_id_hold, id_ex_bubble; decrement cnt; go to RUN when cnt reaches 1.
  - hz is not re-evaluated in LWAIT, because the load has left EX.
- Total bubbles per hazard equals exactly LOAD_BUBBLES.

Flush vector:
- BR_STAGE = 2: flush = 011.
- BR_STAGE = 3: flush = 111.
- Otherwise 000.
- flush is a single-cycle pulse per redirect cycle.

Simultaneous / boundary:
- redirect and hz in the same cycle: redirect wins; no hold, no bubble.
- redirect during LWAIT: flush pulses, cnt clears, next state RUN; hold/bubble deasserted that cycle. The stalled consumer is squashed.
- Back-to-back redirects: each cycle pulses flush independently.
- rst asserted mid-LWAIT: RUN next cycle; no residual bubble.
- busy = (state == LWAIT).

Optional Feature:
HAZ_PERF_EN
- Defined: adds outputs perf_stall (32) and perf_flush (32).
  - perf_stall increments on every cycle with id_ex_bubble = 1.
  - perf_flush increments on every redirect cycle.
  - Both counters wrap at 2^32 and reset to 0 on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
Shared package mips_pkg holds:
- fwd select encodings FWD_RF = 2'b00, FWD_MEM = 2'b10, FWD_WB = 2'b01;
- FSM state enum;
- flush bit indices FL_IFID, FL_IDEX, FL_EXMEM.

One sub-module, fwd_sel: purely combinational. hazard_ctrl instantiates it twice, once for A and once for B.

Test Plan:
1. add r3 in MEM, add in EX reading rs = r3, r3 also in WB -> fwd_a = 10, fwd_b = 00; rd = 0 case -> fwd_a = 00.
2. lw r5 in EX, ID reads rt = r5, LOAD_BUBBLES = 1 -> one cycle of pc_hold / if_id_hold / id_ex_bubble = 1, then 0; busy stays 0.
3. Same stimulus with LOAD_BUBBLES = 3 -> exactly 3 consecutive bubble cycles, busy = 1 for cycles 2–3.
4. lw hazard and redirect in the same cycle, BR_STAGE = 3 -> flush = 111, no bubble, state RUN.
5. redirect in the 2nd LWAIT cycle (LOAD_BUBBLES = 4) -> flush = 011 that cycle, hold deasserted, busy = 0 next cycle.
6. rst high mid-LWAIT; with HAZ_PERF_EN after 2 hazards × 3 bubbles and 1 redirect -> perf_stall = 6, perf_flush = 1; after rst, all outputs and counters are 0.
